rate_hex_display: RTL and testbench
===================================

RATE_HEX_DISPLAY -- requirements
Module: rate_hex_display

Interface
REQ-001 The block SHALL have parameters: COUNT_PERIOD, default 50000000, clock cycles per measurement window.
REQ-002 The block SHALL have parameters: DIGITS, default 6, number of 7-segment digits; accumulator width ACC_W = 4*DIGITS.
REQ-003 The block SHALL require COUNT_PERIOD >= 4*DIGITS+4 and 1 <= DIGITS <= 8; elaboration SHALL fail otherwise.
REQ-004 Port clk, input, 1, sole clock.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port ev, input, 1, event strobe; each high cycle counts one event.
REQ-007 Port mode_dec, input, 1, 0 = hexadecimal display, 1 = decimal display.
REQ-008 Port blank_lz, input, 1, 1 = blank leading zero digits.
REQ-009 Port value, output, ACC_W, displayed nibbles (binary in hex mode, BCD in decimal mode), digit 0 in [3:0].
REQ-010 Port hex, output, 7*DIGITS, active-low segments, digit n in [7n+6:7n], bit order g..a.
REQ-011 Port update, output, 1, one-cycle pulse when value/hex change.
REQ-012 Port overflow, output, 1, last window saturated or clamped.
REQ-013 Port busy, output, 1, high while decimal conversion runs.

Function
REQ-014 Period counter SHALL count 0..COUNT_PERIOD-1 and wrap; cycle T is the cycle it equals COUNT_PERIOD-1.
REQ-015 Accumulator SHALL increment on ev, saturating at 2^ACC_W-1; ev at cycle T SHALL be included in the closing window; ev at T+1 SHALL belong to the next window.
REQ-016 At T the accumulator (including T's ev) SHALL be snapshotted, mode_dec and blank_lz sampled, and accumulator cleared to 0 for T+1.
REQ-017 FSM states IDLE, HEX, CONV, OUT; IDLE->HEX (mode_dec=0) or IDLE->CONV (mode_dec=1) at T; HEX->OUT; CONV->OUT after exactly 4*DIGITS shift-add-3 iterations; OUT->IDLE.
REQ-018 Hex mode: value = snapshot; overflow = snapshot saturated; update high at T+2.
REQ-019 Decimal mode: snapshot > 10^DIGITS-1 SHALL clamp to 10^DIGITS-1 with overflow=1; BCD via sequential double-dabble; update high at T+2+4*DIGITS.
REQ-020 busy SHALL be high exactly while in CONV.
REQ-021 mode_dec/blank_lz changes between snapshots SHALL NOT affect display until the next T.
REQ-022 Segment codes 0..F: 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1011000,0000000,0010000,0001000,0000011,1000110,0100001,0000110,0001110; blank = 1111111.
REQ-023 With sampled blank_lz=1, every digit above the most significant nonzero digit SHALL be blank; digit 0 SHALL never be blanked.
REQ-024 value, hex, overflow SHALL change only in the update cycle and hold otherwise.

Reset
REQ-025 Reset SHALL force: period counter 0, accumulator 0, FSM IDLE, value 0, every hex digit 1000000, update 0, overflow 0, busy 0, effective the cycle after reset is sampled high.
REQ-026 Reset during CONV SHALL abort conversion with no update pulse; counting restarts from 0 on the first cycle after release.

Verification (COUNT_PERIOD=2000, DIGITS=4 unless stated)
REQ-027 Hex: mode_dec=0, 42 ev pulses in window -> value=0x002A, digit1=0100100, digit0=0001000, update at T+2, overflow=0.
REQ-028 Decimal: mode_dec=1, 1234 ev -> busy high T+2..T+17, value=0x1234, update at T+18.
REQ-029 Blanking: mode_dec=1, blank_lz=1, 42 ev -> digits 3,2 = 1111111, digit1=0011001, digit0=0100100.
REQ-030 Boundary: ev only at T and T+1 -> first window value=1; next window includes the T+1 event.
REQ-031 Overflow: COUNT_PERIOD=20000, ev always high, mode_dec=1 -> value=0x9999, overflow=1; mode_dec=0 next window -> value=0x4E20, overflow=0.
REQ-032 Reset at T+5 in decimal mode -> reset values next cycle, no update pulse, next window counts from 0.

Source files
------------

// File: rtl/rate_hex_display.sv
// rate_hex_display
//   Counts ev strobes over a fixed window of COUNT_PERIOD clocks. At the end
//   of each window it shows the count on DIGITS seven-segment digits, either
//   as hex or as decimal. Decimal uses a sequential double-dabble conversion.
//
// Ports
//   clk       sole clock
//   reset     synchronous, active-high
//   ev        event strobe, one event per high cycle
//   mode_dec  0 = hex display, 1 = decimal display (sampled at window end)
//   blank_lz  1 = blank leading zero digits (sampled at window end)
//   value     displayed nibbles, digit 0 in [3:0] (binary or BCD)
//   hex       active-low segments, digit n in [7n+6:7n], bit order g..a
//   update    one-cycle pulse in the cycle value/hex/overflow change
//   overflow  last window saturated (hex) or clamped (decimal)
//   busy      high while double-dabble iterations are running
//
// FSM states
//   state  | meaning
//   IDLE   | counting, waiting for the window's last cycle (T)
//   HEX    | snapshot is shown as-is; result latched on exit
//   CONV   | first cycle clamps/loads, then 4*DIGITS shift-add-3 iterations
//   OUT    | update cycle, new result visible on the outputs
module rate_hex_display #(
    parameter int  COUNT_PERIOD = 50000000,
    parameter int  DIGITS       = 6,
    localparam int ACC_W        = 4 * DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ev,
    input  logic                  mode_dec,
    input  logic                  blank_lz,
    output logic [ACC_W-1:0]      value,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  update,
    output logic                  overflow,
    output logic                  busy
);

    if (COUNT_PERIOD < 4 * DIGITS + 4 || DIGITS < 1 || DIGITS > 8) begin : g_param_check
        $error("rate_hex_display: COUNT_PERIOD must be >= 4*DIGITS+4 and DIGITS in 1..8");
    end

    function automatic logic [ACC_W-1:0] dec_max_f();
        longint p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            p = p * 10;
        end
        return ACC_W'(p - 1);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1011000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    localparam int               CNT_W    = $clog2(COUNT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_PERIOD - 1);
    localparam int               IT_W     = $clog2(ACC_W + 1);
    localparam logic [IT_W-1:0]  IT_LOAD  = IT_W'(ACC_W);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [ACC_W-1:0] DEC_MAX  = dec_max_f();

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEX,
        S_CONV,
        S_OUT
    } state_t;

    state_t              state, nxt;
    logic [CNT_W-1:0]    cnt;
    logic                is_t;
    logic [ACC_W-1:0]    acc, acc_inc, snap_now, snap_r;
    logic                blank_r;
    logic [ACC_W-1:0]    bin_r, bcd_r, bcd_adj, dd_bin, dd_bcd;
    logic [IT_W-1:0]     iter_cnt;
    logic                conv_load;
    logic                ovf_r;
    logic [ACC_W-1:0]    res_nib;
    logic                res_ovf;
    logic [7*DIGITS-1:0] seg_nxt;
    logic                zero_run;

    assign is_t     = (cnt == CNT_LAST);
    assign acc_inc  = (acc == ACC_MAX) ? acc : acc + ACC_W'(1);
    // Snapshot includes the event arriving in the closing cycle itself.
    assign snap_now = ev ? acc_inc : acc;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (is_t) nxt = mode_dec ? S_CONV : S_HEX;
            S_HEX:   nxt = S_OUT;
            S_CONV:  if (!conv_load && iter_cnt == IT_W'(1)) nxt = S_OUT;
            S_OUT:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
    // combined {bcd, bin} register left by one.
    always_comb begin
        bcd_adj = bcd_r;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_r[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
            end
        end
        {dd_bcd, dd_bin} = {bcd_adj, bin_r} << 1;
    end

    // Result presented on the transition into OUT.
    always_comb begin
        res_nib  = dd_bcd;
        res_ovf  = ovf_r;
        seg_nxt  = '1;
        zero_run = 1'b1;
        if (state == S_HEX) begin
            res_nib = snap_r;
            res_ovf = (snap_r == ACC_MAX);
        end
        for (int d = DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (res_nib[4*d +: 4] == 4'd0);
            if (blank_r && zero_run && d != 0) begin
                seg_nxt[7*d +: 7] = 7'b1111111;
            end else begin
                seg_nxt[7*d +: 7] = seg7(res_nib[4*d +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            snap_r    <= '0;
            blank_r   <= 1'b0;
            bin_r     <= '0;
            bcd_r     <= '0;
            iter_cnt  <= '0;
            conv_load <= 1'b0;
            ovf_r     <= 1'b0;
            value     <= '0;
            hex       <= {DIGITS{7'b1000000}};
            update    <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= is_t ? '0 : cnt + CNT_W'(1);

            if (is_t) begin
                acc     <= '0;
                snap_r  <= snap_now;
                blank_r <= blank_lz;
            end else if (ev) begin
                acc <= acc_inc;
            end

            if (state == S_IDLE && nxt == S_CONV) begin
                conv_load <= 1'b1;
            end

            if (state == S_CONV) begin
                if (conv_load) begin
                    conv_load <= 1'b0;
                    bin_r     <= (snap_r > DEC_MAX) ? DEC_MAX : snap_r;
                    ovf_r     <= (snap_r > DEC_MAX);
                    bcd_r     <= '0;
                    iter_cnt  <= IT_LOAD;
                end else begin
                    bin_r    <= dd_bin;
                    bcd_r    <= dd_bcd;
                    iter_cnt <= iter_cnt - IT_W'(1);
                end
            end

            // Busy covers the shift-add-3 iterations, not the load cycle.
            busy   <= (state == S_CONV) && (nxt == S_CONV);
            update <= (nxt == S_OUT);

            if (nxt == S_OUT) begin
                value    <= res_nib;
                hex      <= seg_nxt;
                overflow <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_rate_hex_display.sv
module tb_rate_hex_display;

    localparam int CP_A = 2000;
    localparam int CP_B = 20000;
    localparam int D    = 4;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1011000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
    localparam logic [6:0] SX = 7'b1111111;
    localparam logic [27:0] RST_HEX = {S0, S0, S0, S0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, ev_a, mode_a, blank_a;
    logic [15:0] value_a;
    logic [27:0] hex_a;
    logic        update_a, overflow_a, busy_a;

    logic        reset_b, ev_b, mode_b, blank_b;
    logic [15:0] value_b;
    logic [27:0] hex_b;
    logic        update_b, overflow_b, busy_b;

    rate_hex_display #(.COUNT_PERIOD(CP_A), .DIGITS(D)) dut (
        .clk(clk), .reset(reset_a), .ev(ev_a), .mode_dec(mode_a), .blank_lz(blank_a),
        .value(value_a), .hex(hex_a), .update(update_a), .overflow(overflow_a), .busy(busy_a)
    );

    rate_hex_display #(.COUNT_PERIOD(CP_B), .DIGITS(D)) dut_big (
        .clk(clk), .reset(reset_b), .ev(ev_b), .mode_dec(mode_b), .blank_lz(blank_b),
        .value(value_b), .hex(hex_b), .update(update_b), .overflow(overflow_b), .busy(busy_b)
    );

    typedef struct {
        int          pat;   // 0 random positions, 1 only last cycle, 2 only first cycle
        int          n;
        bit          md;
        bit          bl;
        logic [15:0] v;
        logic [27:0] h;
        bit          o;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    logic [6:0] seg_tab [16];

    int nerr, nchecks;
    int cyc, win_cnt;
    int pend_cyc;
    logic [15:0] pend_value, held_value, ovr_value;
    logic [27:0] pend_hex, held_hex, ovr_hex;
    bit          pend_ovf, held_ovf, ovr_ovf, ovr_en;
    int busy_lo, busy_hi;
    int bad_upd, bad_hold, bad_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        nchecks++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Behavioural reference: saturate/clamp the count, split into digits
    // arithmetically, look up segments, blank above the top nonzero digit.
    function automatic void model_window(input int n, input bit md, input bit bl,
                                         output logic [15:0] v, output logic [27:0] h,
                                         output bit o);
        int x;
        int msd;
        if (!md) begin
            x = (n > 65535) ? 65535 : n;
            o = (x == 65535);
            v = 16'(x);
        end else begin
            x = (n > 9999) ? 9999 : n;
            o = (n > 9999);
            v = {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
        end
        msd = 0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] != 4'd0) msd = i;
        h = '1;
        for (int i = 0; i < D; i++) h[7*i +: 7] = (bl && i > msd) ? SX : seg_tab[v[4*i +: 4]];
    endfunction

    // Consumes the inputs already driven for cycle cyc, advances one clock,
    // then checks the outputs of the new cycle.
    task automatic tick_a();
        logic [15:0] mv;
        logic [27:0] mh;
        bit          mo;
        if (ev_a) win_cnt++;
        if (cyc % CP_A == CP_A - 1) begin
            model_window(win_cnt, mode_a, blank_a, mv, mh, mo);
            if (ovr_en) begin
                mv = ovr_value; mh = ovr_hex; mo = ovr_ovf; ovr_en = 0;
            end
            pend_value = mv; pend_hex = mh; pend_ovf = mo;
            pend_cyc = cyc + (mode_a ? 2 + 4 * D : 2);
            if (mode_a) begin
                busy_lo = cyc + 2; busy_hi = cyc + 1 + 4 * D;
            end
            win_cnt = 0;
        end
        @(posedge clk); #1;
        cyc++;
        if (cyc == pend_cyc) begin
            chk("update_pulse", update_a, 1);
            chk("value", value_a, pend_value);
            chk("hex", hex_a, pend_hex);
            chk("overflow", overflow_a, pend_ovf);
            held_value = pend_value; held_hex = pend_hex; held_ovf = pend_ovf;
            pend_cyc = -1;
        end else if (update_a !== 1'b0) begin
            bad_upd++;
        end
        if (value_a !== held_value || hex_a !== held_hex || overflow_a !== held_ovf) bad_hold++;
        if (busy_a !== (cyc >= busy_lo && cyc <= busy_hi)) bad_busy++;
    endtask

    task automatic check_agg();
        chk("spurious_update_cycles", 32'(bad_upd), 0);
        chk("output_hold_violations", 32'(bad_hold), 0);
        chk("busy_mismatch_cycles", 32'(bad_busy), 0);
        bad_upd = 0; bad_hold = 0; bad_busy = 0;
    endtask

    task automatic run_window(input int pat, input int n, input bit md, input bit bl);
        int placed;
        placed = 0;
        for (int i = 0; i < CP_A; i++) begin
            case (pat)
                1:       ev_a = (i == CP_A - 1);
                2:       ev_a = (i == 0);
                default: ev_a = ($urandom_range(CP_A - 1 - i) < 32'(n - placed));
            endcase
            placed += int'(ev_a);
            if (i == CP_A - 1) begin
                mode_a = md; blank_a = bl;
            end else begin
                mode_a = 1'($urandom_range(1)); blank_a = 1'($urandom_range(1));
            end
            tick_a();
        end
        check_agg();
    endtask

    task automatic reset_a_seq();
        reset_a = 1'b1; ev_a = 1'b1;
        @(posedge clk); #1;
        chk("rst_value", value_a, 0);
        chk("rst_hex", hex_a, RST_HEX);
        chk("rst_update", update_a, 0);
        chk("rst_overflow", overflow_a, 0);
        chk("rst_busy", busy_a, 0);
        reset_a = 1'b0;
        cyc = 0; win_cnt = 0; pend_cyc = -1; busy_lo = 1; busy_hi = 0;
        held_value = '0; held_hex = RST_HEX; held_ovf = 0;
    endtask

    initial begin
        seg_tab = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, SA, SB, SC, SD, SE, SF};
        vecs[0]  = '{0, 42,   1'b0, 1'b0, 16'h002A, {S0, S0, S2, SA}, 1'b0};
        vecs[1]  = '{0, 1234, 1'b1, 1'b0, 16'h1234, {S1, S2, S3, S4}, 1'b0};
        vecs[2]  = '{0, 42,   1'b1, 1'b1, 16'h0042, {SX, SX, S4, S2}, 1'b0};
        vecs[3]  = '{0, 0,    1'b1, 1'b1, 16'h0000, {SX, SX, SX, S0}, 1'b0};
        vecs[4]  = '{0, 2000, 1'b1, 1'b0, 16'h2000, {S2, S0, S0, S0}, 1'b0};
        vecs[5]  = '{0, 2000, 1'b0, 1'b1, 16'h07D0, {SX, S7, SD, S0}, 1'b0};
        vecs[6]  = '{0, 255,  1'b0, 1'b0, 16'h00FF, {S0, S0, SF, SF}, 1'b0};
        vecs[7]  = '{0, 1005, 1'b1, 1'b1, 16'h1005, {S1, S0, S0, S5}, 1'b0};
        vecs[8]  = '{0, 966,  1'b0, 1'b1, 16'h03C6, {SX, S3, SC, S6}, 1'b0};
        vecs[9]  = '{1, 1,    1'b0, 1'b0, 16'h0001, {S0, S0, S0, S1}, 1'b0};
        vecs[10] = '{2, 1,    1'b0, 1'b0, 16'h0001, {S0, S0, S0, S1}, 1'b0};
        vecs[11] = '{0, 0,    1'b0, 1'b1, 16'h0000, {SX, SX, SX, S0}, 1'b0};
        vecs[12] = '{0, 1999, 1'b1, 1'b1, 16'h1999, {S1, S9, S9, S9}, 1'b0};

        nerr = 0; nchecks = 0;
        bad_upd = 0; bad_hold = 0; bad_busy = 0; ovr_en = 0;
        reset_a = 1'b1; ev_a = 1'b0; mode_a = 1'b0; blank_a = 1'b0;
        reset_b = 1'b1; ev_b = 1'b1; mode_b = 1'b1; blank_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fork
            begin : branch_a
                reset_a_seq();
                for (int i = 0; i < NV; i++) begin
                    ovr_en = 1; ovr_value = vecs[i].v; ovr_hex = vecs[i].h; ovr_ovf = vecs[i].o;
                    run_window(vecs[i].pat, vecs[i].n, vecs[i].md, vecs[i].bl);
                end
                for (int i = 0; i < 6; i++) begin
                    run_window(0, int'($urandom_range(CP_A)), 1'($urandom_range(1)),
                               1'($urandom_range(1)));
                end
                // Reset five cycles after T while a decimal conversion runs.
                run_window(0, 777, 1'b1, 1'b0);
                for (int i = 0; i < 4; i++) begin
                    ev_a = 1'($urandom_range(1)); mode_a = 1'($urandom_range(1));
                    tick_a();
                end
                chk("busy_at_t_plus_5", busy_a, 1);
                reset_a_seq();
                ovr_en = 1; ovr_value = 16'h012C; ovr_hex = {S0, S1, S2, SC}; ovr_ovf = 0;
                run_window(0, 300, 1'b0, 1'b0);
                run_window(0, int'($urandom_range(CP_A)), 1'b1, 1'b1);
                ev_a = 1'b0;
                for (int i = 0; i < 25; i++) tick_a();
                check_agg();
                chk("last_update_seen", (pend_cyc < 0), 1);
            end
            begin : branch_b
                reset_b = 1'b0;
                mode_b = 1'b1;
                for (int k = 1; k <= 40010; k++) begin
                    @(posedge clk); #1;
                    if (k == 20001) chk("b_busy_t_plus_2", busy_b, 1);
                    if (k == 20016) chk("b_no_early_update", update_b, 0);
                    if (k == 20017) begin
                        chk("b_dec_update", update_b, 1);
                        chk("b_dec_value_clamped", value_b, 16'h9999);
                        chk("b_dec_overflow", overflow_b, 1);
                        chk("b_busy_done", busy_b, 0);
                    end
                    if (k == 20100) mode_b = 1'b0;
                    if (k == 40001) begin
                        chk("b_hex_update", update_b, 1);
                        chk("b_hex_value", value_b, 16'h4E20);
                        chk("b_hex_overflow", overflow_b, 0);
                    end
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
